pipe_stage_elastic: RTL and testbench

//  Parametrised pipeline stage register for the vector ASIP, replacing the fixed
//  per-stage latch banks between decode, execute and memory. Carries control bits,

---
 rtl/pipe_stage_elastic.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main + skid entry with valid/ready flow control,
// synchronous squash and a saturating back-pressure stall counter.
module pipe_stage_elastic #(
    parameter int CTRL_W  = 16,
    parameter int DATA_W  = 128,
    parameter int NUM_OPS = 2,
    parameter int ADDR_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [ADDR_W-1:0]           in_dest,
    input  logic [NUM_OPS*ADDR_W-1:0]   in_src,
    input  logic [NUM_OPS*DATA_W-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [ADDR_W-1:0]           out_dest,
    output logic [NUM_OPS*ADDR_W-1:0]   out_src,
    output logic [NUM_OPS*DATA_W-1:0]   out_data,
    output logic [1:0]                  occupancy,
    output logic [15:0]                 stall_cnt
);

    localparam int SRC_W = NUM_OPS * ADDR_W;
    localparam int OPS_W = NUM_OPS * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;

    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [ADDR_W-1:0]   main_dest_q, main_dest_d;
    logic [SRC_W-1:0]    main_src_q, main_src_d;
    logic [OPS_W-1:0]    main_data_q, main_data_d;

    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [ADDR_W-1:0]   skid_dest_q, skid_dest_d;
    logic [SRC_W-1:0]    skid_src_q, skid_src_d;
    logic [OPS_W-1:0]    skid_data_q, skid_data_d;

    logic [15:0]         stall_q, stall_d;

    logic                accept;
    logic                issue;

    // in_ready comes straight from state, never from out_ready
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = 2'(state_q);

    assign accept = in_valid && in_ready;
    assign issue  = out_valid && out_ready;

    assign out_ctrl  = main_ctrl_q;
    assign out_dest  = main_dest_q;
    assign out_src   = main_src_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_q;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_dest_d = main_dest_q;
        main_src_d  = main_src_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_dest_d = skid_dest_q;
        skid_src_d  = skid_src_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // squashed entries become bubbles: no control, no destination
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            main_dest_d = '0;
            skid_ctrl_d = '0;
            skid_dest_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_dest_d = in_dest;
                        main_src_d  = in_src;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && issue) begin
                        main_ctrl_d = in_ctrl;
                        main_dest_d = in_dest;
                        main_src_d  = in_src;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_dest_d = in_dest;
                        skid_src_d  = in_src;
                        skid_data_d = in_data;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (issue) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_dest_d = skid_dest_q;
                        main_src_d  = skid_src_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_dest_q <= '0;
            main_src_q  <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_dest_q <= '0;
            skid_src_q  <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_dest_q <= main_dest_d;
            main_src_q  <= main_src_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_dest_q <= skid_dest_d;
            skid_src_q  <= skid_src_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pipe_stage_elastic;

    localparam int CW = 16;
    localparam int DW = 128;
    localparam int NO = 2;
    localparam int AW = 4;
    localparam int SW = NO * AW;
    localparam int OW = NO * DW;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [AW-1:0] dest;
        logic [SW-1:0] src;
        logic [OW-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [AW-1:0] in_dest, out_dest;
    logic [SW-1:0] in_src, out_src;
    logic [OW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_elastic #(
        .CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_dest(in_dest),
        .in_src(in_src), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_dest(out_dest),
        .out_src(out_src), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight items in order, plus what the main
    // register shows once it has drained (last head, squashed on flush).
    item_t q[$];
    item_t ghost;
    int    stall_m = 0;
    bit    started = 0;

    always @(posedge clk) begin
        item_t it;
        bit    ov, ir, acc, iss;
        started = 1;
        if (rst) begin
            q.delete();
            ghost   = '0;
            stall_m = 0;
        end else begin
            ov  = q.size() > 0;
            ir  = q.size() < 2;
            acc = in_valid && ir;
            iss = ov && out_ready;
            if (ov && !out_ready && stall_m < 65535) stall_m++;
            if (flush) begin
                if (q.size() > 0) ghost = q[0];
                q.delete();
                ghost.ctrl = '0;
                ghost.dest = '0;
            end else begin
                if (iss) ghost = q.pop_front();
                if (acc) begin
                    it.ctrl = in_ctrl;
                    it.dest = in_dest;
                    it.src  = in_src;
                    it.data = in_data;
                    q.push_back(it);
                end
            end
        end
    end

    always @(negedge clk) begin
        item_t h;
        if (started) begin
            h = (q.size() > 0) ? q[0] : ghost;
            chk("m_out_valid", OW'(out_valid), OW'(q.size() > 0));
            chk("m_in_ready", OW'(in_ready), OW'(q.size() < 2));
            chk("m_occupancy", OW'(occupancy), OW'(q.size()));
            chk("m_out_ctrl", OW'(out_ctrl), OW'(h.ctrl));
            chk("m_out_dest", OW'(out_dest), OW'(h.dest));
            chk("m_out_src", OW'(out_src), OW'(h.src));
            chk("m_out_data", out_data, h.data);
            chk("m_stall_cnt", OW'(stall_cnt), OW'(stall_m));
        end
    end

    task automatic rand_payload(input logic [CW-1:0] c);
        logic [OW-1:0] d;
        for (int k = 0; k < OW / 32; k++) d[k*32 +: 32] = $urandom;
        in_ctrl = c;
        in_dest = AW'($urandom);
        in_src  = SW'($urandom);
        in_data = d;
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        rand_payload(16'hABCD);
        @(posedge clk);
        @(posedge clk);
        nxt();
        chk("rst_out_valid", OW'(out_valid), '0);
        chk("rst_occupancy", OW'(occupancy), '0);
        chk("rst_stall", OW'(stall_cnt), '0);
        chk("rst_in_ready", OW'(in_ready), OW'(1));
        chk("rst_out_ctrl", OW'(out_ctrl), '0);
        chk("rst_out_dest", OW'(out_dest), '0);
        chk("rst_out_src", OW'(out_src), '0);
        chk("rst_out_data", out_data, '0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            nxt();
            if (i > 1) begin
                chk("bb_ctrl", OW'(out_ctrl), OW'(i - 1));
                chk("bb_occ", OW'(occupancy), OW'(1));
            end
            in_valid = 1'b1;
            rand_payload(CW'(i));
        end
        nxt();
        chk("bb_ctrl", OW'(out_ctrl), OW'(8));
        chk("bb_stall", OW'(stall_cnt), '0);
        in_valid = 1'b0;

        nxt();
        out_ready = 1'b0; in_valid = 1'b1; rand_payload(16'h00A0);
        nxt();
        chk("s3_out_a", OW'(out_ctrl), OW'(16'h00A0));
        chk("s3_rdy_a", OW'(in_ready), OW'(1));
        rand_payload(16'h00B0);
        nxt();
        chk("s3_rdy_b", OW'(in_ready), '0);
        chk("s3_occ", OW'(occupancy), OW'(2));
        rand_payload(16'h00C0);
        nxt();
        chk("s3_hold", OW'(out_ctrl), OW'(16'h00A0));
        chk("s3_rdy_c", OW'(in_ready), '0);
        nxt();
        chk("s3_stall", OW'(stall_cnt), OW'(3));
        out_ready = 1'b1;
        nxt();
        chk("s3_out_b", OW'(out_ctrl), OW'(16'h00B0));
        chk("s3_occ1", OW'(occupancy), OW'(1));
        nxt();
        chk("s3_out_c", OW'(out_ctrl), OW'(16'h00C0));
        chk("s3_stall2", OW'(stall_cnt), OW'(3));
        in_valid = 1'b0;
        nxt();
        chk("s3_empty", OW'(out_valid), '0);

        out_ready = 1'b0; in_valid = 1'b1; rand_payload(16'h0011);
        nxt();
        rand_payload(16'h0022);
        nxt();
        chk("s4_full", OW'(occupancy), OW'(2));
        flush = 1'b1; out_ready = 1'b1; rand_payload(16'h0033);
        nxt();
        chk("s4_valid", OW'(out_valid), '0);
        chk("s4_ctrl", OW'(out_ctrl), '0);
        chk("s4_dest", OW'(out_dest), '0);
        chk("s4_occ", OW'(occupancy), '0);
        chk("s4_rdy", OW'(in_ready), OW'(1));
        chk("s4_stall", OW'(stall_cnt), OW'(4));

        rand_payload(16'h0055);
        nxt();
        chk("s5_valid", OW'(out_valid), '0);
        flush = 1'b0; rand_payload(16'h0066);
        nxt();
        chk("s5_valid2", OW'(out_valid), OW'(1));
        chk("s5_ctrl", OW'(out_ctrl), OW'(16'h0066));
        in_valid = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_payload(CW'($urandom));
        end
        nxt();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; rand_payload(16'h0077);
        nxt();
        in_valid = 1'b0;
        repeat (66000) nxt();
        chk("s6_sat", OW'(stall_cnt), OW'(16'hFFFF));
        chk("s6_valid", OW'(out_valid), OW'(1));
        rst = 1'b1;
        nxt();
        chk("s6_rst", OW'(stall_cnt), '0);
        chk("s6_rst_valid", OW'(out_valid), '0);
        rst = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
